// File: rtl/paddle_motion_ctrl.sv
// Per-player Pong paddle position controller: synchronised buttons, one move per frame_tick,
// clamped at the playfield bounds. Define PADDLE_ACCEL_EN to ramp speed while a direction is held.
module paddle_motion_ctrl #(
    parameter int Y_W         = 10,
    parameter int SCREEN_H    = 480,
    parameter int PADDLE_H    = 80,
    parameter int STEP_MIN    = 2,
    parameter int STEP_MAX    = 8,
    parameter int ACCEL_TICKS = 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           frame_tick,
    input  logic           up,
    input  logic           down,
    input  logic           recenter,
    output logic [Y_W-1:0] paddle_y,
    output logic [3:0]     speed,
    output logic           moving,
    output logic           at_top,
    output logic           at_bottom
);

    generate
        if (!(SCREEN_H > PADDLE_H && SCREEN_H < (1 << Y_W))) begin : g_bad_geometry
            $error("paddle_motion_ctrl: need PADDLE_H < SCREEN_H < 2**Y_W");
        end
        if (STEP_MIN < 1 || STEP_MAX < STEP_MIN || STEP_MAX > 15 || ACCEL_TICKS < 1) begin : g_bad_step
            $error("paddle_motion_ctrl: need 1 <= STEP_MIN <= STEP_MAX <= 15, ACCEL_TICKS >= 1");
        end
    endgenerate

    localparam logic [Y_W-1:0] Y_MAX      = Y_W'(SCREEN_H - PADDLE_H);
    localparam logic [Y_W-1:0] CENTER     = Y_W'(SCREEN_H / 2 - PADDLE_H / 2);
    localparam logic [3:0]     STEP_MIN_V = 4'(STEP_MIN);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] MOVE_UP   = 2'd1;
    localparam logic [1:0] MOVE_DOWN = 2'd2;

    // Position math is done one bit wider than paddle_y so the clamp sees the true sum.
    function automatic logic [Y_W-1:0] step_up(input logic [Y_W-1:0] y, input logic [3:0] s);
        logic [Y_W:0] sum;
        sum = {1'b0, y} + (Y_W+1)'(s);
        if (sum > {1'b0, Y_MAX}) return Y_MAX;
        else                     return sum[Y_W-1:0];
    endfunction

    function automatic logic [Y_W-1:0] step_down(input logic [Y_W-1:0] y, input logic [3:0] s);
        if ({1'b0, y} < (Y_W+1)'(s)) return '0;
        else                         return y - Y_W'(s);
    endfunction

    logic [1:0] up_sync_p0, dn_sync_p0;
    logic [1:0] state;
    logic [1:0] dir_state;
    logic       entering;
    logic [3:0] move_step;

    // Synchroniser stage: bit 1 is the metastability-safe copy used by the FSM
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            up_sync_p0 <= 2'b00;
            dn_sync_p0 <= 2'b00;
        end else begin
            up_sync_p0 <= {up_sync_p0[0], up};
            dn_sync_p0 <= {dn_sync_p0[0], down};
        end
    end

    always_comb begin
        dir_state = IDLE;
        if (up_sync_p0[1] && !dn_sync_p0[1])      dir_state = MOVE_UP;
        else if (dn_sync_p0[1] && !up_sync_p0[1]) dir_state = MOVE_DOWN;
        entering  = (dir_state != state);
        move_step = entering ? STEP_MIN_V : speed;
    end

    logic [3:0] speed_next;

`ifdef PADDLE_ACCEL_EN
    localparam int CNT_W = (ACCEL_TICKS < 2) ? 1 : $clog2(ACCEL_TICKS + 1);

    logic [CNT_W-1:0] accel_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] cnt_next;

    // The entering move is the first move at STEP_MIN, so it counts toward ACCEL_TICKS.
    always_comb begin
        cnt_inc    = (entering ? '0 : accel_cnt) + CNT_W'(1);
        cnt_next   = cnt_inc;
        speed_next = move_step;
        if (cnt_inc == CNT_W'(ACCEL_TICKS)) begin
            cnt_next   = '0;
            speed_next = (move_step >= 4'(STEP_MAX)) ? 4'(STEP_MAX) : move_step + 4'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                                  accel_cnt <= '0;
        else if (recenter)                          accel_cnt <= '0;
        else if (frame_tick && dir_state == IDLE)   accel_cnt <= '0;
        else if (frame_tick)                        accel_cnt <= cnt_next;
    end
`else
    assign speed_next = STEP_MIN_V;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            paddle_y <= CENTER;
            speed    <= STEP_MIN_V;
            state    <= IDLE;
        end else if (recenter) begin
            paddle_y <= CENTER;
            speed    <= STEP_MIN_V;
            state    <= IDLE;
        end else if (frame_tick) begin
            state <= dir_state;
            if (dir_state == IDLE) begin
                speed <= STEP_MIN_V;
            end else begin
                speed    <= speed_next;
                paddle_y <= (dir_state == MOVE_UP) ? step_up(paddle_y, move_step)
                                                   : step_down(paddle_y, move_step);
            end
        end
    end

    assign moving    = (state != IDLE);
    assign at_top    = (paddle_y == Y_MAX);
    assign at_bottom = (paddle_y == '0);

endmodule

// File: tb/tb_paddle_motion_ctrl.sv
// Scoreboard bench for paddle_motion_ctrl: stimulus pushes expected state, a monitor pops and compares.
module tb_paddle_motion_ctrl;
    localparam int Y_W         = 10;
    localparam int SCREEN_H    = 480;
    localparam int PADDLE_H    = 80;
    localparam int STEP_MIN    = 2;
    localparam int STEP_MAX    = 8;
    localparam int ACCEL_TICKS = 4;
    localparam int Y_MAX       = SCREEN_H - PADDLE_H;
    localparam int CENTER      = SCREEN_H / 2 - PADDLE_H / 2;
`ifdef PADDLE_ACCEL_EN
    localparam bit ACCEL = 1'b1;
`else
    localparam bit ACCEL = 1'b0;
`endif

    logic           clock = 1'b0;
    logic           reset, frame_tick, up, down, recenter;
    logic [Y_W-1:0] paddle_y;
    logic [3:0]     speed;
    logic           moving, at_top, at_bottom;

    paddle_motion_ctrl #(
        .Y_W(Y_W), .SCREEN_H(SCREEN_H), .PADDLE_H(PADDLE_H),
        .STEP_MIN(STEP_MIN), .STEP_MAX(STEP_MAX), .ACCEL_TICKS(ACCEL_TICKS)
    ) dut (
        .clock(clock), .reset(reset), .frame_tick(frame_tick), .up(up), .down(down),
        .recenter(recenter), .paddle_y(paddle_y), .speed(speed), .moving(moving),
        .at_top(at_top), .at_bottom(at_bottom)
    );

    always #5 clock = ~clock;

    typedef struct {
        int y;
        int spd;
        bit mv;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: position, current speed, direction (-1/0/+1), moves made at current speed
    int m_y, m_spd, m_dir, m_moves;
    bit upd;

    task automatic check(input string name, input logic [31:0] act, input int req);
        n_tests++;
        if (act !== 32'(req)) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic check_state(input string tag, input exp_t e);
        check({tag, ".paddle_y"},  32'(paddle_y),  e.y);
        check({tag, ".speed"},     32'(speed),     e.spd);
        check({tag, ".moving"},    32'(moving),    int'(e.mv));
        check({tag, ".at_top"},    32'(at_top),    int'(e.y == Y_MAX));
        check({tag, ".at_bottom"}, 32'(at_bottom), int'(e.y == 0));
    endtask

    function automatic exp_t model_now();
        exp_t e;
        e.y   = m_y;
        e.spd = m_spd;
        e.mv  = (m_dir != 0);
        return e;
    endfunction

    task automatic model_reset();
        m_y = CENTER; m_spd = STEP_MIN; m_dir = 0; m_moves = 0;
    endtask

    task automatic model_tick(input bit u, input bit d);
        int nd;
        nd = (u && !d) ? 1 : ((d && !u) ? -1 : 0);
        if (nd == 0) begin
            m_dir = 0; m_spd = STEP_MIN; m_moves = 0;
        end else begin
            if (nd != m_dir) begin
                m_dir = nd; m_spd = STEP_MIN; m_moves = 0;
            end
            if (nd > 0) m_y = (m_y + m_spd > Y_MAX) ? Y_MAX : m_y + m_spd;
            else        m_y = (m_y < m_spd) ? 0 : m_y - m_spd;
            if (ACCEL) begin
                m_moves++;
                if (m_moves == ACCEL_TICKS) begin
                    m_spd   = (m_spd + 1 > STEP_MAX) ? STEP_MAX : m_spd + 1;
                    m_moves = 0;
                end
            end
        end
    endtask

    // Buttons settle through the synchroniser before the tick is issued.
    task automatic do_tick(input bit u, input bit d);
        @(negedge clock);
        up = u; down = d;
        repeat (2) @(negedge clock);
        frame_tick = 1'b1;
        model_tick(u, d);
        exp_q.push_back(model_now());
        @(negedge clock);
        frame_tick = 1'b0;
    endtask

    task automatic do_recenter(input bit with_tick);
        @(negedge clock);
        recenter   = 1'b1;
        frame_tick = with_tick;
        model_reset();
        exp_q.push_back(model_now());
        @(negedge clock);
        recenter   = 1'b0;
        frame_tick = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clock);
        check("drain_queue_empty", 32'(exp_q.size()), 0);
    endtask

    always @(posedge clock) upd = (frame_tick || recenter) && !reset;

    always @(negedge clock) begin
        if (upd) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_update: paddle_y=%0d speed=%0d, no expectation queued",
                         paddle_y, speed);
            end else begin
                check_state("tick", exp_q.pop_front());
            end
        end
    end

    initial begin
        int combo;
        bit u, d;
        reset = 1'b1; frame_tick = 1'b0; up = 1'b0; down = 1'b0; recenter = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        check_state("reset", model_now());
        reset = 1'b0;

        for (int i = 0; i < 10; i++) do_tick(1'b0, 1'b0);
        for (int i = 0; i < 3; i++)  do_tick(1'b1, 1'b0);
        do_tick(1'b0, 1'b0);

        do_recenter(1'b0);
        for (int i = 0; i < 12; i++) do_tick(1'b1, 1'b0);
        do_tick(1'b0, 1'b1);

        // Run into the top bound and hold, then into the bottom bound and hold
        for (int i = 0; i < 200 && m_y != Y_MAX; i++) do_tick(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) do_tick(1'b1, 1'b0);
        for (int i = 0; i < 300 && m_y != 0; i++) do_tick(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) do_tick(1'b0, 1'b1);

        for (int i = 0; i < 4; i++) do_tick(1'b1, 1'b1);

        for (int i = 0; i < 3; i++) do_tick(1'b1, 1'b0);
        do_recenter(1'b0);
        do_tick(1'b0, 1'b1);
        do_recenter(1'b1);

        combo = 1;
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                do_recenter(1'($urandom_range(0, 1)));
            end else begin
                if ($urandom_range(0, 3) == 0) combo = $urandom_range(0, 3);
                u = combo[0];
                d = combo[1];
                do_tick(u, d);
            end
        end

        // Asynchronous reset mid-move, asserted between clock edges
        for (int i = 0; i < 6; i++) do_tick(1'b1, 1'b0);
        drain();
        #2 reset = 1'b1;
        model_reset();
        #1 check_state("async_reset", model_now());
        @(negedge clock);
        reset = 1'b0;
        up = 1'b0;
        repeat (3) @(negedge clock);
        check_state("post_reset_hold", model_now());

        drain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
